fetch_queue: RTL and testbench



---
 rtl/fetch_pkg.sv | 13 +
 rtl/fq_mem.sv | 24 ++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: reset PC, the canonical NOP, and the
// {pc, inst} pair that travels from fetch to decode.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fq_mem.sv
// Unreset register array for the fetch queue: one synchronous write port and
// one asynchronous read port.
module fq_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through queue between fetch and decode, with a one-cycle
// flush for branch/jump redirects.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [PC_W-1:0]          push_pc_i,
  input  logic [INST_W-1:0]        push_inst_i,
  output logic                     pop_valid_o,
  input  logic                     pop_ready_i,
  output logic [PC_W-1:0]          pop_pc_o,
  output logic [INST_W-1:0]        pop_inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = PC_W + INST_W;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_we;
  logic [DW-1:0] w_rdata;

  // Ready/valid come from registered count only: a full queue refuses a push
  // even if a pop fires in the same cycle.
  assign push_ready_o = (r_count != CW'(DEPTH));
  assign pop_valid_o  = (r_count != '0);
  assign count_o      = r_count;

  assign w_push = push_valid_i && push_ready_o;
  assign w_pop  = pop_valid_o && pop_ready_i;
  assign w_we   = w_push && !flush_i && !rst_i;

  fq_mem #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_we),
    .waddr_i (r_wptr),
    .wdata_i ({push_pc_i, push_inst_i}),
    .raddr_i (r_rptr),
    .rdata_o (w_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is unreset, so the head is masked to zero while empty.
  always_comb begin
    pop_pc_o   = '0;
    pop_inst_o = '0;
    if (pop_valid_o) begin
      pop_pc_o   = w_rdata[DW-1:INST_W];
      pop_inst_o = w_rdata[INST_W-1:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed test-plan phases plus random
// traffic, checked against a queue-based reference model.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_pc = '0;
  logic [31:0] push_inst = '0;
  logic        pop_valid;
  logic        pop_ready = 1'b0;
  logic [31:0] pop_pc;
  logic [31:0] pop_inst;
  logic [2:0]  count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  fq_entry_t   exp_q[$];
  int unsigned m_cnt = 0;
  logic [31:0] next_pc = '0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_pc_i    (push_pc),
    .push_inst_i  (push_inst),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .pop_pc_o     (pop_pc),
    .pop_inst_o   (pop_inst),
    .count_o      (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: whenever the DUT offers a head that decode takes (and no
  // flush/reset overrides it), compare against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (pop_valid === 1'b1 && pop_ready && !flush && !rst) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", {32'h0, pop_pc}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          fq_entry_t e;
          e = exp_q.pop_front();
          chk("pop_entry", {pop_pc, pop_inst}, {e.pc, e.inst});
        end
      end
    end
  end

  // One cycle: apply inputs (we sit just after a rising edge), advance the
  // model across the next edge, then check the registered status.
  task automatic cyc(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic pr, input logic fl, input logic rs);
    logic acc_push, acc_pop;
    push_valid = pv; push_pc = pc; push_inst = inst;
    pop_ready = pr; flush = fl; rst = rs;
    acc_push = pv && (m_cnt != DEPTH);
    acc_pop  = pr && (m_cnt != 0);
    @(posedge clk);
    #1;
    if (rs || fl) begin
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (acc_push) exp_q.push_back('{pc: pc, inst: inst});
      m_cnt = m_cnt + (acc_push ? 1 : 0) - (acc_pop ? 1 : 0);
    end
    chk("count", {61'h0, count}, 64'(m_cnt));
    chk("pop_valid", {63'h0, pop_valid}, 64'(m_cnt != 0));
    chk("push_ready", {63'h0, push_ready}, 64'(m_cnt != DEPTH));
    if (m_cnt == 0) chk("empty_mask", {pop_pc, pop_inst}, 64'h0);
  endtask

  task automatic idle(input int unsigned n, input logic pr);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, pr, 1'b0, 1'b0);
  endtask

  task automatic push4(input logic pr);
    cyc(1'b1, 32'h00, 32'h1111_1111, pr, 1'b0, 1'b0);
    cyc(1'b1, 32'h04, 32'h2222_2222, pr, 1'b0, 1'b0);
    cyc(1'b1, 32'h08, 32'h3333_3333, pr, 1'b0, 1'b0);
    cyc(1'b1, 32'h0C, 32'h4444_4444, pr, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset then idle
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    chk("reset_count", {61'h0, count}, 64'h0);
    chk("reset_ready", {63'h0, push_ready}, 64'h1);

    // Fill, hold off a fifth push, then drain in order
    push4(1'b0);
    chk("full_count", {61'h0, count}, 64'h4);
    chk("full_ready", {63'h0, push_ready}, 64'h0);
    cyc(1'b1, 32'h10, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h10, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b1);

    // Full with simultaneous push and pop: push refused, head pops
    push4(1'b0);
    cyc(1'b1, 32'h10, 32'h5555_5555, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", {61'h0, count}, 64'h3);
    chk("fullpp_ready", {63'h0, push_ready}, 64'h1);
    idle(4, 1'b1);

    // Streaming with pointer wrap
    for (int unsigned i = 0; i < 10; i++)
      cyc(1'b1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Flush beats a same-cycle push and pop
    cyc(1'b1, 32'h20, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h24, 32'h0000_0024, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h28, 32'h0000_0028, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h40, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b0);
    chk("flush_count", {61'h0, count}, 64'h0);
    cyc(1'b1, 32'h80, 32'hBBBB_BBBB, 1'b0, 1'b0, 1'b0);
    chk("after_flush_head", {pop_pc, pop_inst}, {32'h80, 32'hBBBB_BBBB});
    idle(2, 1'b1);

    // Reset mid-stream with a coincident push
    cyc(1'b1, 32'h90, NOP_INST, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h94, NOP_INST, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h98, NOP_INST, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_pc", {32'h0, pop_pc}, {32'h0, RESET_PC});
    idle(2, 1'b1);
    cyc(1'b1, 32'hA0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b1);

    // Random traffic with occasional flush and reset
    next_pc = 32'h1000;
    for (int unsigned i = 0; i < 400; i++) begin
      logic pv, pr, fl, rs;
      pv = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 59) == 0);
      cyc(pv, next_pc, $urandom, pr, fl, rs);
      next_pc = next_pc + 32'h4;
    end
    idle(6, 1'b1);
    chk("drained_model", 64'(exp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
